// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants, sync polarity encodings and the helpers that
// derive per-axis totals and sync bounds from porch/pulse widths.
package vga_timing_pkg;

  localparam int COUNT_W   = 10;
  localparam int COUNT_MAX = 1 << COUNT_W;

  // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical).
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  typedef enum logic {
    RUN_IDLE   = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_e;

  typedef struct packed {
    int total;
    int sync_start;
    int sync_end;
  } axis_bounds_t;

  function automatic axis_bounds_t axis_bounds(input int visible, input int front,
                                               input int sync, input int back);
    axis_bounds_t b;
    b.total      = visible + front + sync + back;
    b.sync_start = visible + front;
    b.sync_end   = visible + front + sync;
    return b;
  endfunction

  // Every segment must be at least one unit and the axis must fit the counter.
  function automatic bit axis_ok(input int visible, input int front,
                                 input int sync, input int back);
    return (visible >= 1) && (front >= 1) && (sync >= 1) && (back >= 1) &&
           (visible + front + sync + back <= COUNT_MAX);
  endfunction

endpackage

// File: rtl/vga_timing_generator_axis.sv
// One raster axis: an enable-gated wrapping counter whose visible/sync flags
// are registered from the next count so they line up with the count itself.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int LIMIT      = 800,
  parameter int VISIBLE    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               refresh,
  output logic [COUNT_W-1:0] count,
  output logic               wrap,
  output logic               in_visible,
  output logic               in_sync
);

  localparam logic [COUNT_W-1:0] LAST      = COUNT_W'(LIMIT - 1);
  localparam logic [COUNT_W-1:0] VIS_END   = COUNT_W'(VISIBLE);
  localparam logic [COUNT_W-1:0] SYNC_LO   = COUNT_W'(SYNC_START);
  localparam logic [COUNT_W-1:0] SYNC_HI   = COUNT_W'(SYNC_END);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  logic [COUNT_W-1:0] count_next;

  always_comb begin
    wrap       = enable && (count == LAST);
    count_next = count;
    if (enable) begin
      count_next = wrap ? '0 : count + COUNT_ONE;
    end
  end

  // refresh re-evaluates the flags without moving the count (used at start-up).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      in_visible <= 1'b0;
      in_sync    <= 1'b0;
    end else if (enable || refresh) begin
      count      <= count_next;
      in_visible <= (count_next < VIS_END);
      in_sync    <= (count_next >= SYNC_LO) && (count_next < SYNC_HI);
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing on the USB clock, advanced by the pix_en strobe: sync
// levels, active flag, pixel/line coordinates and line/frame start pulses.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HS_POL    = SYNC_ACTIVE_LOW,
  parameter bit VS_POL    = SYNC_ACTIVE_LOW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [COUNT_W-1:0] x,
  output logic [COUNT_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam axis_bounds_t HB = axis_bounds(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam axis_bounds_t VB = axis_bounds(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam int H_TOTAL      = HB.total;
  localparam int H_SYNC_START = HB.sync_start;
  localparam int H_SYNC_END   = HB.sync_end;
  localparam int V_TOTAL      = VB.total;
  localparam int V_SYNC_START = VB.sync_start;
  localparam int V_SYNC_END   = VB.sync_end;

  if (!axis_ok(H_VISIBLE, H_FRONT, H_SYNC, H_BACK)) begin : g_bad_h
    $error("vga_timing_generator: horizontal timing invalid or exceeds counter range");
  end
  if (!axis_ok(V_VISIBLE, V_FRONT, V_SYNC, V_BACK)) begin : g_bad_v
    $error("vga_timing_generator: vertical timing invalid or exceeds counter range");
  end

  run_state_e state_q;
  run_state_e state_d;
  logic       start;
  logic       h_en;
  logic       h_wrap;
  logic       h_visible;
  logic       h_in_sync;
  logic       v_wrap;
  logic       v_visible;
  logic       v_in_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == RUN_IDLE) && pix_en) begin
      state_d = RUN_ACTIVE;
    end
  end

  // The first strobe only starts the raster; later strobes advance x.
  always_comb begin
    start = 1'b0;
    h_en  = 1'b0;
    if (state_q == RUN_IDLE) begin
      start = pix_en;
    end else begin
      h_en = pix_en;
    end
  end

  vga_axis_counter #(
    .LIMIT      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END)
  ) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .enable     (h_en),
    .refresh    (start),
    .count      (x),
    .wrap       (h_wrap),
    .in_visible (h_visible),
    .in_sync    (h_in_sync)
  );

  vga_axis_counter #(
    .LIMIT      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END)
  ) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .enable     (h_wrap),
    .refresh    (start),
    .count      (y),
    .wrap       (v_wrap),
    .in_visible (v_visible),
    .in_sync    (v_in_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= start || h_wrap;
      frame_start <= start || v_wrap;
    end
  end

  assign hsync  = h_in_sync ? HS_POL : ~HS_POL;
  assign vsync  = v_in_sync ? VS_POL : ~VS_POL;
  assign active = h_visible && v_visible;

endmodule
